// File: rtl/if_ent_arbiter.sv
// Round-robin arbiter sharing one IfEnt compare-and-adjust datapath among NREQ requesters.
// Returns result, requester ID and divide-by-zero flag over a single valid/ready channel.

module if_ent (
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] xout
);
   logic [7:0] sq;
   logic [7:0] div;

   always_comb begin
      sq   = a * a;
      div  = (a == 8'd0) ? 8'd1 : a;
      xout = '0;
      if (a > b)
         xout = a;
      else if (b > a)
         xout = {a[6:0], 1'b0} - b;
      else if (a != 8'd0)
         xout = (sq / div) + 8'd1;
   end
endmodule

module if_ent_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = (NREQ > 2) ? $clog2(NREQ) : 1,
   parameter int CW   = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [NREQ-1:0]   REQ_VALID,
   input  logic [8*NREQ-1:0] REQ_A,
   input  logic [8*NREQ-1:0] REQ_B,
   output logic [NREQ-1:0]   REQ_READY,
   output logic              RES_VALID,
   input  logic              RES_READY,
   output logic [7:0]        RES_DATA,
   output logic [IDW-1:0]    RES_ID,
   output logic              RES_ERR,
   output logic [CW-1:0]     DONE_CNT
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t         state, state_nx;
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] gid;
   logic [IDW-1:0] gnt;
   logic [IDW-1:0] cand;
   logic           gnt_any;
   logic [7:0]     op_a, op_b, xout;
   logic           err;

   if_ent u_dp (
      .a    (op_a),
      .b    (op_b),
      .xout (xout)
   );

   // First valid requester scanning from ptr upward, wrapping at NREQ.
   always_comb begin
      gnt_any = 1'b0;
      gnt     = '0;
      cand    = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = IDW'((32'(ptr) + k) % NREQ);
         if (!gnt_any && REQ_VALID[cand]) begin
            gnt_any = 1'b1;
            gnt     = cand;
         end
      end
   end

   always_comb begin
      state_nx  = state;
      REQ_READY = '0;
      RES_VALID = 1'b0;
      case (state)
         IDLE: begin
            if (gnt_any && !RST) begin
               REQ_READY[gnt] = 1'b1;
               state_nx       = EXEC;
            end
         end
         EXEC: state_nx = RESP;
         RESP: begin
            RES_VALID = 1'b1;
            if (RES_READY)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         state <= IDLE;
      else
         state <= state_nx;
   end

   assign err = (op_a == 8'd0) && (op_b == 8'd0);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         op_a     <= '0;
         op_b     <= '0;
         gid      <= '0;
         ptr      <= '0;
         RES_DATA <= '0;
         RES_ID   <= '0;
         RES_ERR  <= 1'b0;
         DONE_CNT <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt_any) begin
                  op_a <= REQ_A[8*gnt +: 8];
                  op_b <= REQ_B[8*gnt +: 8];
                  gid  <= gnt;
               end
            end
            EXEC: begin
               RES_DATA <= err ? '0 : xout;
               RES_ID   <= gid;
               RES_ERR  <= err;
            end
            RESP: begin
               // Just-served requester drops to lowest priority.
               if (RES_READY) begin
                  ptr      <= (gid == IDW'(NREQ - 1)) ? '0 : gid + 1'b1;
                  DONE_CNT <= DONE_CNT + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/if_ent_arbiter.md
Name: if_ent_arbiter

Overview:
- Shares one combinational IfEnt compare-and-adjust datapath (8-bit A, B -> XOUT) among NREQ requesters.
- Accepts operand pairs over per-requester valid/ready handshakes, with round-robin fairness.
- Registers operands into the datapath and captures its result; returns result, requester ID and error flag over a single valid/ready response channel.
- Sits between the request sources and the shared datapath instance, which it instantiates internally.

Parameters:
- NREQ, 4: number of requesters, 2..8.
- IDW, clog2(NREQ) (min 1): width of requester ID.
- CW, 16: width of completed-transaction counter.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- REQ_VALID  in  NREQ  bit i = requester i has an operand pair.
- REQ_A  in  8*NREQ  operand A; requester i at bits [8i+7:8i], unsigned.
- REQ_B  in  8*NREQ  operand B; same packing.
- REQ_READY  out  NREQ  one-hot or zero; bit i = pair i accepted this cycle.
- RES_VALID  out  1  result available.
- RES_READY  in  1  downstream accepts result.
- RES_DATA  out  8  datapath result.
- RES_ID  out  IDW  index of originating requester.
- RES_ERR  out  1  1 = divide-by-zero case (A==B==0).
- DONE_CNT  out  CW  count of completed response handshakes, wraps.

Behaviour:
- Clock/reset: one clock CLK; RST is asynchronous, active-high.
- Reset values: state IDLE; RES_VALID=0, RES_DATA=0, RES_ID=0, RES_ERR=0, DONE_CNT=0; RR pointer=0; operand registers=0.
- REQ_READY is 0 during and after reset until IDLE is evaluated.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - If any REQ_VALID, grant g = first set index scanning ptr, ptr+1, ... mod NREQ.
  - REQ_READY[g]=1 combinationally in this cycle only.
  - Latch REQ_A[g], REQ_B[g] and g; go to EXEC.
  - With no request, stay in IDLE with REQ_READY=0.
- EXEC (1 cycle):
  - Latched operands drive the datapath.
  - At the clock edge, capture XOUT into RES_DATA; RES_ID=g; RES_ERR=(A==0 && B==0).
  - When RES_ERR=1, RES_DATA is forced to 0 (datapath divides by zero).
  - Go to RESP.
- RESP:
  - RES_VALID=1; RES_DATA, RES_ID, RES_ERR held stable until handshake.
  - On RES_VALID && RES_READY: RES_VALID falls next cycle; ptr=(g+1) mod NREQ; DONE_CNT+=1 (wraps 2^CW-1 -> 0); go to IDLE.
  - REQ_READY=0 throughout EXEC and RESP; no new request accepted until back in IDLE.
- Latency and throughput:
  - Request accepted at edge t -> RES_VALID high from t+2.
  - Minimum spacing of accepts is 3 cycles when RES_READY is held high.
- Datapath function (golden model, mod 256):
  - A>B -> A.
  - B>A -> (2A - B).
  - A==B, A!=0 -> ((A*A) mod 256)/A + 1, integer division.
  - A==B==0 -> RES_ERR=1, RES_DATA=0.
- Fairness: ptr changes only on response handshake. The just-served requester becomes lowest priority, so no requester waits more than NREQ-1 transactions.
- Handshake rules:
  - A requester deasserting REQ_VALID without a ready is legal; it is simply not granted.
  - REQ_A/REQ_B are sampled only in the grant cycle.
  - RES_READY may be high before RES_VALID; it has no effect outside RESP.
- Reset mid-operation: any in-flight transaction is dropped with no response; DONE_CNT and ptr clear; the first grant after release follows ptr=0.

Test Plan:
- Single request: NREQ=4, req1 A=10, B=3, RES_READY=1 -> REQ_READY=0010 for 1 cycle; 2 cycles later RES_VALID=1, RES_DATA=10, RES_ID=1, RES_ERR=0; DONE_CNT=1.
- Equal operands: A=B=20 -> RES_DATA=8 (400 mod 256=144, 144/20=7, +1). A=B=3 -> 4. A=3, B=10 -> RES_DATA=252. A=B=0 -> RES_ERR=1, RES_DATA=0.
- Round-robin: all four REQ_VALID held high, RES_READY=1 -> grant order 0,1,2,3,0 at accept cycles 3 apart; RES_ID matches.
- Backpressure: RES_READY=0 for 5 cycles in RESP -> RES_VALID and RES_DATA stable; REQ_READY stays 0; no second grant; completes when RES_READY rises.
- Reset mid-EXEC: assert RST asynchronously during EXEC -> RES_VALID=0 immediately, no response emitted, DONE_CNT=0; next request from req2 is granted normally.
- Counter wrap: with CW=4, complete 17 transactions -> DONE_CNT reads 1.
